// File: rtl/game_pkg.sv
// Shared encodings, default rates and limits for the falling-man game controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int unsigned DEF_FALL_DIV        = 3000000;
    localparam int unsigned DEF_MOVE_DIV        = 1000000;
    localparam int unsigned DEF_SCROLL_DIV_INIT = 5000000;
    localparam int unsigned DEF_SCROLL_STEP     = 500000;
    localparam int unsigned DEF_SCROLL_DIV_MIN  = 2000000;
    localparam int unsigned DEF_SEC_DIV         = 50000000;
    localparam int unsigned DEF_LEVEL_SECS      = 10;
    localparam int unsigned DEF_DYING_CYCLES    = 100000000;
    localparam int unsigned DEF_BLINK_DIV       = 12500000;

    localparam logic [9:0] SCORE_MAX = 10'd999;
    localparam logic [2:0] LEVEL_MAX = 3'd7;

    // Scroll period shrinks with level but never drops below the floor; no underflow.
    function automatic logic [31:0] scroll_period(input logic [2:0]  lvl,
                                                  input logic [31:0] init,
                                                  input logic [31:0] step,
                                                  input logic [31:0] floor_p);
        logic [31:0] dec;
        dec = {29'd0, lvl} * step;
        if (dec >= init || (init - dec) < floor_p)
            return floor_p;
        return init - dec;
    endfunction

endpackage

// File: rtl/game_if.sv
// Game-flow bus between the sequencer (master) and the position datapath (slave).
interface game_if;
    logic       start_n;
    logic       fail;
    logic [2:0] state;
    logic       game_active;
    logic       clear;
    logic       tick_fall;
    logic       tick_move;
    logic       tick_scroll;
    logic [9:0] score;
    logic [2:0] level;
    logic       blink;

    modport master (
        input  start_n, fail,
        output state, game_active, clear, tick_fall, tick_move, tick_scroll,
               score, level, blink
    );

    modport slave (
        output start_n, fail,
        input  state, game_active, clear, tick_fall, tick_move, tick_scroll,
               score, level, blink
    );
endinterface

// File: rtl/game_sequencer_rate_tick.sv
// Free-running 0..period-1 counter; wrap_o pulses for the cycle the counter sits at period-1.
module rate_tick (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_i,
    input  logic        clr_i,
    input  logic [31:0] period_i,
    output logic        wrap_o
);
    logic [31:0] cnt_q;
    logic        term;

    assign term   = (cnt_q == period_i - 32'd1);
    assign wrap_o = run_i & term;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= 32'd0;
        else if (clr_i)
            cnt_q <= 32'd0;
        else if (run_i)
            cnt_q <= term ? 32'd0 : cnt_q + 32'd1;
    end
endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: start-key handshake, play/over FSM, score/level and all rate ticks.
import game_pkg::*;

module game_sequencer #(
    parameter int unsigned FALL_DIV        = DEF_FALL_DIV,
    parameter int unsigned MOVE_DIV        = DEF_MOVE_DIV,
    parameter int unsigned SCROLL_DIV_INIT = DEF_SCROLL_DIV_INIT,
    parameter int unsigned SCROLL_STEP     = DEF_SCROLL_STEP,
    parameter int unsigned SCROLL_DIV_MIN  = DEF_SCROLL_DIV_MIN,
    parameter int unsigned SEC_DIV         = DEF_SEC_DIV,
    parameter int unsigned LEVEL_SECS      = DEF_LEVEL_SECS,
    parameter int unsigned DYING_CYCLES    = DEF_DYING_CYCLES,
    parameter int unsigned BLINK_DIV       = DEF_BLINK_DIV
) (
    input  logic   clk,
    input  logic   resetn,
    game_if.master bus
);
    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic        press;
    logic        active_q, clear_q, fall_q, move_q, scroll_q, blink_q;
    logic [9:0]  score_q;
    logic [2:0]  level_q;
    logic [31:0] lvl_cnt_q;
    logic [31:0] per_q;

    logic in_play, in_clear, in_dying, stay_play;
    logic fall_wrap, move_wrap, scroll_wrap, sec_wrap, blink_wrap, hold_wrap;

    assign in_play   = (state_q == ST_PLAY);
    assign in_clear  = (state_q == ST_CLEAR);
    assign in_dying  = (state_q == ST_DYING);
    assign stay_play = (state_d == ST_PLAY);

    // Key idles high, so synchronizer resets to 1 to avoid a phantom press.
    assign press = prev_q & ~sync_q[1];

    rate_tick u_fall   (.clk(clk), .resetn(resetn), .run_i(in_play), .clr_i(in_clear),
                        .period_i(FALL_DIV), .wrap_o(fall_wrap));
    rate_tick u_move   (.clk(clk), .resetn(resetn), .run_i(in_play), .clr_i(in_clear),
                        .period_i(MOVE_DIV), .wrap_o(move_wrap));
    rate_tick u_scroll (.clk(clk), .resetn(resetn), .run_i(in_play), .clr_i(in_clear),
                        .period_i(per_q), .wrap_o(scroll_wrap));
    rate_tick u_sec    (.clk(clk), .resetn(resetn), .run_i(in_play), .clr_i(in_clear),
                        .period_i(SEC_DIV), .wrap_o(sec_wrap));
    rate_tick u_blink  (.clk(clk), .resetn(resetn), .run_i(in_dying), .clr_i(~in_dying),
                        .period_i(BLINK_DIV), .wrap_o(blink_wrap));
    rate_tick u_hold   (.clk(clk), .resetn(resetn), .run_i(in_dying), .clr_i(~in_dying),
                        .period_i(DYING_CYCLES), .wrap_o(hold_wrap));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (press) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY:  if (bus.fail) state_d = ST_DYING;
            ST_DYING: if (hold_wrap) state_d = ST_OVER;
            ST_OVER:  if (press) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= ST_IDLE;
            active_q  <= 1'b0;
            clear_q   <= 1'b0;
            fall_q    <= 1'b0;
            move_q    <= 1'b0;
            scroll_q  <= 1'b0;
            blink_q   <= 1'b0;
            score_q   <= 10'd0;
            level_q   <= 3'd0;
            lvl_cnt_q <= 32'd0;
            per_q     <= 32'd0;
        end else begin
            sync_q   <= {sync_q[0], bus.start_n};
            prev_q   <= sync_q[1];
            state_q  <= state_d;
            active_q <= stay_play;
            clear_q  <= (state_d == ST_CLEAR);
            // A terminal count coinciding with fail is swallowed: state_d is no longer PLAY.
            fall_q   <= fall_wrap & stay_play;
            move_q   <= move_wrap & stay_play;
            scroll_q <= scroll_wrap & stay_play;
            blink_q  <= (state_d == ST_DYING) ? (blink_q ^ blink_wrap) : 1'b0;

            if (state_d == ST_CLEAR) begin
                score_q   <= 10'd0;
                level_q   <= 3'd0;
                lvl_cnt_q <= 32'd0;
                per_q     <= SCROLL_DIV_INIT;
            end else begin
                if (scroll_wrap)
                    per_q <= scroll_period(level_q, SCROLL_DIV_INIT, SCROLL_STEP, SCROLL_DIV_MIN);
                if (sec_wrap && stay_play && score_q != SCORE_MAX) begin
                    score_q <= score_q + 10'd1;
                    if (lvl_cnt_q == LEVEL_SECS - 32'd1) begin
                        lvl_cnt_q <= 32'd0;
                        if (level_q != LEVEL_MAX)
                            level_q <= level_q + 3'd1;
                    end else begin
                        lvl_cnt_q <= lvl_cnt_q + 32'd1;
                    end
                end
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.game_active = active_q;
    assign bus.clear       = clear_q;
    assign bus.tick_fall   = fall_q;
    assign bus.tick_move   = move_q;
    assign bus.tick_scroll = scroll_q;
    assign bus.score       = score_q;
    assign bus.level       = level_q;
    assign bus.blink       = blink_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed game sequences with randomized lengths/key noise against an arithmetic game model.
module tb_game_sequencer;
    localparam int FD = 4, MD = 3, SI = 8, SS = 2, SM = 4, SD = 5, LS = 2, DC = 6, BD = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    game_if bus ();

    game_sequencer #(
        .FALL_DIV(FD), .MOVE_DIV(MD), .SCROLL_DIV_INIT(SI), .SCROLL_STEP(SS),
        .SCROLL_DIV_MIN(SM), .SEC_DIV(SD), .LEVEL_SECS(LS), .DYING_CYCLES(DC),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    function automatic int f_score(input int k);
        return (k / SD > 999) ? 999 : k / SD;
    endfunction

    function automatic int f_level(input int s);
        return (s / LS > 7) ? 7 : s / LS;
    endfunction

    function automatic int f_period(input int lvl);
        int p;
        p = SI - lvl * SS;
        return (p < SM) ? SM : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input int st, input int act, input int clr,
                               input int tf, input int tm, input int ts,
                               input int sc, input int lv, input int bl);
        chk({tag, ".state"}, {29'd0, bus.state}, st);
        chk({tag, ".active"}, {31'd0, bus.game_active}, act);
        chk({tag, ".clear"}, {31'd0, bus.clear}, clr);
        chk({tag, ".tick_fall"}, {31'd0, bus.tick_fall}, tf);
        chk({tag, ".tick_move"}, {31'd0, bus.tick_move}, tm);
        chk({tag, ".tick_scroll"}, {31'd0, bus.tick_scroll}, ts);
        chk({tag, ".score"}, {22'd0, bus.score}, sc);
        chk({tag, ".level"}, {29'd0, bus.level}, lv);
        chk({tag, ".blink"}, {31'd0, bus.blink}, bl);
    endtask

    // Press the key for 3 cycles and wait (bounded) for the single CLEAR cycle.
    task automatic press_and_clear(output bit ok);
        ok = 1'b0;
        bus.start_n = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (i >= 2) bus.start_n = 1'b1;
            if (bus.state === 3'd1) ok = 1'b1;
        end
        bus.start_n = 1'b1;
        chk("clear_reached", {31'd0, ok}, 1);
        if (ok) chk_outputs("clear", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // One game: PLAY for len cycles then fail; or async reset at PLAY cycle rst_at.
    task automatic game(input int len, input int rst_at);
        bit ok;
        int next_scroll;
        int s, l;
        press_and_clear(ok);
        if (!ok) return;
        next_scroll = SI;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            s = f_score(k);
            l = f_level(s);
            chk_outputs("play", 2, 1, 0, int'(k > 0 && k % FD == 0), int'(k > 0 && k % MD == 0),
                        int'(k == next_scroll), s, l, 0);
            if (k == next_scroll) next_scroll = k + f_period(f_level(f_score(k - 1)));
            if (k == rst_at) begin
                bus.start_n = 1'b1;
                #2 resetn = 1'b0;
                #1 chk_outputs("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                chk_outputs("rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0);
                resetn = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk_outputs("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                return;
            end
            bus.start_n = 1'($urandom_range(0, 1));
            if (k == len - 1) begin
                bus.fail = 1'b1;
                bus.start_n = 1'b1;
            end
        end
        s = f_score(len - 1);
        l = f_level(s);
        for (int d = 0; d <= DC; d++) begin
            @(negedge clk);
            if (d < DC) chk_outputs("dying", 3, 0, 0, 0, 0, 0, s, l, (d / BD) % 2);
            else        chk_outputs("over", 4, 0, 0, 0, 0, 0, s, l, 0);
            bus.fail = (d < DC) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.start_n = (d == 0) ? 1'b0 : 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk_outputs("over_hold", 4, 0, 0, 0, 0, 0, s, l, 0);
        end
    endtask

    initial begin
        bus.start_n = 1'b1;
        bus.fail = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_outputs("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        game(41, -1);
        game(12, -1);
        game(int'($urandom_range(10, 60)), -1);
        game(60, int'($urandom_range(5, 40)));
        game(5100, -1);
        game(int'($urandom_range(10, 30)), -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
